vga_fb_fetch: RTL and testbench
===============================

# vga_fb_fetch

Framebuffer scan-out stage that sits directly downstream of the 640x480 VGA timing controller. It prefetches 32-bit framebuffer words over a Wishbone classic master port into a small word FIFO. During active display it unpacks four RGB332 pixels per word and drives 4-bit-per-channel colour with sync outputs delay-matched to the pixel data.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of pixel 0; must be 4-byte aligned.
- FRAME_WORDS, 76800: words fetched per frame (640*480/4).
- FIFO_DEPTH, 16: word FIFO depth; power of two, minimum 4.
- clock  in  1  pixel clock (25 MHz); all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- hs_in  in  1  horizontal sync from timing controller, low during sync pulse.
- vs_in  in  1  vertical sync from timing controller, low during sync pulse.
- active_in  in  1  display-enable from timing controller.
- wb_adr_o  out  32  byte address, word aligned.
- wb_cyc_o, wb_stb_o  out  1  bus cycle/strobe, always asserted together.
- wb_we_o  out  1  tied 0.
- wb_sel_o  out  4  tied 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  read acknowledge.
- hs_o, vs_o, active_o  out  1  sync and enable inputs delayed by one clock.
- r_o, g_o, b_o  out  4 each  colour channels; 0 whenever active_o is low.
- underflow_o  out  1  sticky; set when a pixel is needed and the FIFO is empty before all words are fetched.

## Operation
- Frame start: the clock edge where a falling edge of vs_in is detected (vs_in=0, registered previous value 1). At frame start:
  - FIFO is flushed.
  - Fetch address returns to BASE_ADDR.
  - Fetched-word counter is cleared.
  - Byte lane returns to 0.
  - underflow_o is cleared.
- Fetch FSM states:
  - IDLE: go to REQ when (FIFO count + outstanding) < FIFO_DEPTH and fetched < FRAME_WORDS.
  - REQ: assert cyc/stb with wb_adr_o held. On wb_ack_i, push wb_dat_i into the FIFO, add 4 to the address, increment fetched, and return to IDLE. Back-to-back cycles are not required.
- Frame start while in REQ: the cycle is held to completion, and the acknowledged data is discarded rather than pushed. The next request uses BASE_ADDR.
- Unpacking: each word holds 4 pixels, consumed little-endian (byte 0 = bits [7:0] first). Each byte is RGB332: R=[7:5], G=[4:2], B=[1:0].
  - Expansion: r_o={R,R[2]}, g_o={G,G[2]}, b_o={B,B}.
- A byte is consumed on every clock with active_in=1. The consuming clock after byte lane 3 pops the FIFO head.
- Empty FIFO with active_in=1:
  - Output is black and the byte lane does not advance.
  - If fetched < FRAME_WORDS, underflow_o is set.
  - If all words are already fetched, no flag is set (trailing active pixels are black).
- Simultaneous push and pop on the same edge is legal; the FIFO count is unchanged.
- Reset values:
  - wb_cyc_o/wb_stb_o=0, wb_adr_o=BASE_ADDR.
  - hs_o=1, vs_o=1, active_o=0.
  - r_o/g_o/b_o=0, underflow_o=0.
  - FIFO empty, FSM IDLE.

## Timing
- Pixel path latency: exactly 1 clock from active_in/hs_in/vs_in to the registered outputs; all outputs are registered.
- First request is issued 1 clock after frame start. With ack on the following clock, each fetch takes 2 clocks, giving 2x the consumption bandwidth.
- Vertical back porch (≥30 lines) fills the FIFO long before the first active pixel.
- Reset mid-bus-cycle drops cyc/stb immediately; a late ack while cyc_o=0 is ignored.

## Structure
- Package vga_pkg holds:
  - rgb332_t packed struct (r[2:0], g[2:0], b[1:0]).
  - rgb444_t struct.
  - Function expand332 implementing the expansion rule.
  - Fetch FSM enum fetch_state_t {IDLE, REQ}.
- Sub-module fb_word_fifo: synchronous FIFO, width 32, depth FIFO_DEPTH, with push/pop/flush and a count output.
- Top level contains the FSM, address/word counters, byte-lane counter and output registers.

## Test plan
- Reset then vs_in falling edge; memory model acks after 1 clock with word 32'hE01C03FF at BASE_ADDR. First four active pixels give r/g/b of F/F/F, 0/0/F, 0/F/0, F/0/0; active_o lags active_in by 1.
- Ack held off 200 clocks while active_in is high: underflow_o=1 and output black. Next frame start clears underflow_o, and the first pixel is correct.
- Full 800x525 frame with FRAME_WORDS=76800: exactly 76800 acked reads; last wb_adr_o=BASE_ADDR+0x4AFFC; no underflow; trailing active pixels beyond 307200 are black.
- vs_in falls while a request is pending with ack delayed 3 clocks: the late data is not displayed, and the next wb_adr_o=BASE_ADDR.
- rst_i pulsed mid-line with cyc_o=1: cyc_o falls immediately, hs_o=vs_o=1, r/g/b=0, and the FIFO is empty after release.
- FIFO_DEPTH=4 with zero-wait acks: FIFO count never exceeds 4, and no request is issued while count+outstanding=4.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared types for the framebuffer scan-out path.
//   rgb332_t      - packed framebuffer pixel, R[7:5] G[4:2] B[1:0]
//   rgb444_t      - 4-bit-per-channel colour as driven to the DAC
//   expand332()   - widens RGB332 to RGB444 by replicating MSBs
//   fetch_state_t - Wishbone fetch FSM states
package vga_pkg;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef enum logic {IDLE, REQ} fetch_state_t;

   // MSB replication keeps full-scale codes at full scale (7 -> F, 3 -> F).
   function automatic rgb444_t expand332(input rgb332_t p);
      rgb444_t c;
      c.r = {p.r, p.r[2]};
      c.g = {p.g, p.g[2]};
      c.b = {p.b, p.b};
      return c;
   endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// fb_word_fifo: synchronous 32-bit word FIFO for prefetched framebuffer data.
//   clock, rst_i   - clock, asynchronous active-high reset
//   i_push, i_data - write a word (caller guarantees not full)
//   i_pop          - retire the head word (caller guarantees not empty)
//   i_flush        - empty the FIFO; overrides push/pop on the same edge
//   o_head         - current head word (valid when !o_empty)
//   o_count        - number of stored words, 0..DEPTH
//   o_empty        - FIFO holds no words
module fb_word_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       rst_i,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [31:0]                i_data,
   output logic [31:0]                o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;

   always_ff @(posedge clock) begin
      if (i_push && !i_flush) r_mem[r_wp] <= i_data;
   end

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clock or posedge rst_i) begin
      if (rst_i) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + 1'b1;
         if (i_pop)  r_rp <= r_rp + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head  = r_mem[r_rp];
   assign o_count = r_cnt;
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: framebuffer scan-out stage behind the VGA timing controller.
// Prefetches 32-bit words over a Wishbone classic read master into a word
// FIFO and unpacks four RGB332 pixels per word (byte 0 first) into RGB444.
//   clock, rst_i             - pixel clock, asynchronous active-high reset
//   hs_in, vs_in, active_in  - timing controller syncs (active low) / enable
//   wb_*                     - Wishbone classic read master
//   hs_o, vs_o, active_o     - timing inputs delayed one clock
//   r_o, g_o, b_o            - colour, black whenever no pixel is shown
//   underflow_o              - sticky: pixel needed, FIFO empty, frame unfinished
module vga_fb_fetch
   import vga_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          FRAME_WORDS = 76800,
   parameter int          FIFO_DEPTH  = 16
) (
   input  logic        clock,
   input  logic        rst_i,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        active_in,
   output logic [31:0] wb_adr_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        hs_o,
   output logic        vs_o,
   output logic        active_o,
   output logic [3:0]  r_o,
   output logic [3:0]  g_o,
   output logic [3:0]  b_o,
   output logic        underflow_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = $clog2(FRAME_WORDS + 1);
   localparam logic [FW-1:0] FRAME_WORDS_C = FW'(FRAME_WORDS);
   localparam logic [CW:0]   DEPTH_C       = (CW+1)'(FIFO_DEPTH);

   fetch_state_t r_state, w_state_nxt;
   logic          r_vs_prev;
   logic          r_discard;     // a cycle straddled frame start; drop its data
   logic [31:0]   r_addr;
   logic [FW-1:0] r_fetched;
   logic [1:0]    r_lane;

   logic          w_frame_start, w_more, w_ack, w_push, w_pop, w_empty;
   logic [31:0]   w_head;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_level;
   rgb332_t       w_pix;
   rgb444_t       w_rgb;

   assign w_frame_start = r_vs_prev & ~vs_in;
   assign w_more        = (r_fetched < FRAME_WORDS_C);
   assign w_ack         = (r_state == REQ) & wb_ack_i;
   assign w_push        = w_ack & ~r_discard & ~w_frame_start;
   assign w_pop         = active_in & ~w_empty & (r_lane == 2'd3) & ~w_frame_start;
   assign w_level       = {1'b0, w_count} + {{CW{1'b0}}, (r_state == REQ)};
   assign w_pix         = rgb332_t'(w_head[{r_lane, 3'b000} +: 8]);
   assign w_rgb         = expand332(w_pix);

   fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .rst_i   (rst_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_frame_start),
      .i_data  (wb_dat_i),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   // Requests are held off on the frame-start edge so the first request of a
   // frame always uses the freshly cleared address and counters.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (!w_frame_start && w_more && (w_level < DEPTH_C)) w_state_nxt = REQ;
         REQ:     if (wb_ack_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_vs_prev   <= 1'b1;
         r_discard   <= 1'b0;
         r_addr      <= BASE_ADDR;
         r_fetched   <= '0;
         r_lane      <= 2'd0;
         underflow_o <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_vs_prev <= vs_in;
         if (w_frame_start) begin
            r_addr      <= BASE_ADDR;
            r_fetched   <= '0;
            r_lane      <= 2'd0;
            underflow_o <= 1'b0;
            r_discard   <= (r_state == REQ) & ~wb_ack_i;
         end else begin
            if (w_ack) r_discard <= 1'b0;
            if (w_push) begin
               r_addr    <= r_addr + 32'd4;
               r_fetched <= r_fetched + 1'b1;
            end
            if (active_in) begin
               if (!w_empty)    r_lane      <= r_lane + 1'b1;
               else if (w_more) underflow_o <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge rst_i) begin
      if (rst_i) begin
         hs_o     <= 1'b1;
         vs_o     <= 1'b1;
         active_o <= 1'b0;
         r_o      <= 4'h0;
         g_o      <= 4'h0;
         b_o      <= 4'h0;
      end else begin
         hs_o     <= hs_in;
         vs_o     <= vs_in;
         active_o <= active_in;
         if (active_in && !w_empty) begin
            r_o <= w_rgb.r;
            g_o <= w_rgb.g;
            b_o <= w_rgb.b;
         end else begin
            r_o <= 4'h0;
            g_o <= 4'h0;
            b_o <= 4'h0;
         end
      end
   end

   assign wb_cyc_o = (r_state == REQ);
   assign wb_stb_o = (r_state == REQ);
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = 4'hF;
   assign wb_adr_o = r_addr;

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Scoreboarded bench for vga_fb_fetch on a scaled-down raster (48x14 total,
// 32x8 active) with FRAME_WORDS smaller than the active area so trailing
// active pixels must be black.
module tb_vga_fb_fetch;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int FW = 56, DEPTH = 4;
   localparam int H_TOT = 48, H_ACT = 32, V_TOT = 14, V_ACT0 = 4, V_ACT1 = 12;

   logic clock = 1'b0, rst_i = 1'b0;
   logic hs_in = 1'b1, vs_in = 1'b1, active_in = 1'b0;
   logic [31:0] wb_adr_o, wb_dat_i = '0;
   logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 1'b0;
   logic [3:0] wb_sel_o, r_o, g_o, b_o;
   logic hs_o, vs_o, active_o, underflow_o;

   vga_fb_fetch #(.BASE_ADDR(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .rst_i(rst_i), .hs_in(hs_in), .vs_in(vs_in), .active_in(active_in),
      .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .hs_o(hs_o), .vs_o(vs_o), .active_o(active_o),
      .r_o(r_o), .g_o(g_o), .b_o(b_o), .underflow_o(underflow_o)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic h, v, a, uf;
      logic [3:0] r, g, b;
   } exp_t;

   exp_t sbq[$];
   int tests = 0, fails = 0;
   bit sb_en = 1'b0, starve = 1'b0, ack_hold = 1'b0;
   int fixed_dly = 3;
   bit prev_vs = 1'b1, uf_m = 1'b0;
   int k = 0;
   int n_acks = 0;
   logic [31:0] last_ack_adr = '0;
   logic [31:0] seed;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == BASE) return 32'hE01C03FF;
      return ((a ^ seed) * 32'h9E3779B1) + 32'h7F4A7C15;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one clock of timing inputs and record what the outputs must show
   // once that edge has registered them.
   task automatic tick_in(input logic h, input logic v, input logic a);
      exp_t e;
      logic [31:0] w;
      logic [7:0] px;
      int rr, gg, bb;
      hs_in = h; vs_in = v; active_in = a;
      @(posedge clock);
      if (!v && prev_vs) begin k = 0; uf_m = 1'b0; end
      e = '0; e.h = h; e.v = v; e.a = a;
      if (a) begin
         if (starve) uf_m = 1'b1;
         else if (k < FW*4) begin
            w  = mem_word(BASE + 32'(4*(k/4)));
            px = 8'(w >> (8*(k%4)));
            rr = int'(px[7:5]); gg = int'(px[4:2]); bb = int'(px[1:0]);
            e.r = 4'(rr*2 + rr/4);
            e.g = 4'(gg*2 + gg/4);
            e.b = 4'(bb*5);
         end
         k++;
      end
      e.uf = uf_m;
      prev_vs = v;
      if (sb_en) sbq.push_back(e);
      #1;
   endtask

   task automatic run_frame(input bit chk_cnt);
      int acks0 = 0;
      for (int ln = 0; ln < V_TOT; ln++)
         for (int c = 0; c < H_TOT; c++) begin
            tick_in(!(c >= 36 && c < 42), !(ln < 2), (ln >= V_ACT0 && ln < V_ACT1 && c < H_ACT));
            if (ln == 0 && c == 0) acks0 = n_acks;
         end
      if (chk_cnt) begin
         chk("frame_ack_count", 32'(n_acks - acks0), 32'(FW));
         chk("last_ack_adr", last_ack_adr, BASE + 32'(4*(FW-1)));
      end
   endtask

   // Wishbone slave memory model with per-transfer wait states.
   initial begin
      int cnt = 0, cur = 0;
      forever begin
         @(posedge clock); #1;
         if (wb_ack_i || !wb_cyc_o) begin
            wb_ack_i = 1'b0; cnt = 0;
            cur = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 1));
         end else if (!ack_hold) begin
            if (cnt >= cur) begin
               wb_ack_i = 1'b1;
               wb_dat_i = mem_word(wb_adr_o);
            end else cnt++;
         end
      end
   end

   // Monitor: pixel/sync scoreboard plus bus invariants.
   always @(negedge clock) begin
      exp_t e, o;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = {hs_o, vs_o, active_o, underflow_o, r_o, g_o, b_o};
         tests++;
         if (o !== e) begin
            fails++;
            $display("FAIL pixel {hs,vs,act,uf,r,g,b}: got %h expected %h", o, e);
         end
      end
      if (!rst_i) begin
         tests++;
         if ((int'(dut.u_fifo.o_count) + (wb_cyc_o ? 1 : 0)) > DEPTH ||
             wb_stb_o !== wb_cyc_o || wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) begin
            fails++;
            $display("FAIL bus_invariant: count=%0d cyc=%b stb=%b we=%b sel=%h required count+cyc<=%0d stb=cyc we=0 sel=f",
                     dut.u_fifo.o_count, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, DEPTH);
         end
      end
      if (wb_cyc_o && wb_ack_i) begin
         n_acks++;
         last_ack_adr = wb_adr_o;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      seed = $urandom;
      #1 rst_i = 1'b1;
      #5;
      chk("rst_cyc", 32'(wb_cyc_o), 0);
      chk("rst_stb", 32'(wb_stb_o), 0);
      chk("rst_adr", wb_adr_o, BASE);
      chk("rst_syncs", {29'd0, hs_o, vs_o, active_o}, 32'b110);
      chk("rst_rgb", {20'd0, r_o, g_o, b_o}, 0);
      chk("rst_uf", 32'(underflow_o), 0);
      @(posedge clock); #1 rst_i = 1'b0;

      // Frame start lands while the third prefetch is outstanding.
      sb_en = 1'b1;
      t = 0;
      while (!(wb_cyc_o && wb_adr_o == BASE + 32'd8) && t < 200) begin
         tick_in(1'b1, 1'b1, 1'b0); t++;
      end
      chk("find_pending_req", 32'(t < 200), 1);
      fork
         run_frame(1'b0);
         begin
            int u = 0;
            while (wb_cyc_o && u < 50) begin @(negedge clock); u++; end
            while (!wb_cyc_o && u < 50) begin @(negedge clock); u++; end
            chk("restart_timeout", 32'(u < 50), 1);
            chk("restart_adr", wb_adr_o, BASE);
            fixed_dly = -1;
         end
      join

      repeat (5) run_frame(1'b1);

      // Starved frame: no acks, every active pixel black, underflow sticks.
      starve = 1'b1; ack_hold = 1'b1;
      run_frame(1'b0);
      starve = 1'b0; ack_hold = 1'b0;
      repeat (30) tick_in(1'b1, 1'b1, 1'b0);
      chk("uf_sticky", 32'(underflow_o), 1);
      run_frame(1'b1);
      chk("uf_cleared", 32'(underflow_o), 0);

      // Reset asserted mid-line with a bus cycle open.
      sb_en = 1'b0;
      tick_in(1'b1, 1'b1, 1'b0);
      fixed_dly = 3;
      tick_in(1'b1, 1'b0, 1'b0);
      t = 0;
      while (!wb_cyc_o && t < 50) begin tick_in(1'b0, 1'b1, 1'b1); t++; end
      chk("reset_find_cyc", 32'(wb_cyc_o), 1);
      #2 rst_i = 1'b1;
      #1;
      chk("midrst_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 0);
      chk("midrst_syncs", {29'd0, hs_o, vs_o, active_o}, 32'b110);
      chk("midrst_rgb", {20'd0, r_o, g_o, b_o}, 0);
      chk("midrst_adr", wb_adr_o, BASE);
      hs_in = 1'b1; active_in = 1'b0; prev_vs = 1'b1;
      @(posedge clock); #2 rst_i = 1'b0;
      #1;
      chk("post_rst_fifo_count", 32'(dut.u_fifo.o_count), 0);
      chk("post_rst_cyc", 32'(wb_cyc_o), 0);
      repeat (5) tick_in(1'b1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
